// File: rtl/ex.sv
// Execute stage: single-cycle RV32I integer ALU plus a 32-step shift-add multiplier (low word).
// Results and write-back control are registered toward EXE/MEM; stall_o holds upstream during a multiply.
module ex #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   illegal_o,
  output logic                   stall_o
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  mcand;
  logic [DATA_WIDTH-1:0]  mplier;
  logic [DATA_WIDTH-1:0]  acc;
  logic [SW-1:0]          count;
  logic                   mul_we;
  logic [RADDR_WIDTH-1:0] mul_waddr;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  legal;
  logic                  is_mul;
  logic                  unused_bits;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign shamt  = op2_i[SW-1:0];
  // Register-number fields are resolved upstream; only opcode/funct fields matter here.
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

  always_comb begin
    alu_res = '0;
    legal   = 1'b0;
    is_mul  = 1'b0;
    case (opcode)
      7'b0010011: begin
        legal = 1'b1;
        case (funct3)
          3'b000: alu_res = op1_i + op2_i;
          3'b010: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
          3'b011: alu_res = {{(DATA_WIDTH-1){1'b0}}, op1_i < op2_i};
          3'b100: alu_res = op1_i ^ op2_i;
          3'b110: alu_res = op1_i | op2_i;
          3'b111: alu_res = op1_i & op2_i;
          3'b001: begin
            legal   = (funct7 == 7'b0000000);
            alu_res = op1_i << shamt;
          end
          default: begin
            legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            alu_res = inst_i[30] ? $unsigned($signed(op1_i) >>> shamt) : (op1_i >> shamt);
          end
        endcase
      end
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          is_mul = (funct3 == 3'b000);
          legal  = is_mul;
        end else if (funct7 == 7'b0000000 ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  alu_res = inst_i[30] ? (op1_i - op2_i) : (op1_i + op2_i);
            3'b001:  alu_res = op1_i << shamt;
            3'b010:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            3'b011:  alu_res = {{(DATA_WIDTH-1){1'b0}}, op1_i < op2_i};
            3'b100:  alu_res = op1_i ^ op2_i;
            3'b101:  alu_res = inst_i[30] ? $unsigned($signed(op1_i) >>> shamt) : (op1_i >> shamt);
            3'b110:  alu_res = op1_i | op2_i;
            default: alu_res = op1_i & op2_i;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Gated by reset so upstream is never frozen while the stage is held in reset.
  assign stall_o = rst_i && ((state == IDLE && is_mul) || state == BUSY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      count       <= '0;
      mul_we      <= 1'b0;
      mul_waddr   <= '0;
      reg_wdata_o <= '0;
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      illegal_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand     <= op1_i;
            mplier    <= op2_i;
            acc       <= '0;
            count     <= '0;
            mul_we    <= reg_we_i;
            mul_waddr <= reg_waddr_i;
            reg_we_o  <= 1'b0;
            illegal_o <= 1'b0;
            state     <= BUSY;
          end else if (!legal) begin
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= reg_waddr_i;
            illegal_o   <= 1'b1;
          end else begin
            reg_wdata_o <= alu_res;
            reg_we_o    <= reg_we_i && (reg_waddr_i != '0);
            reg_waddr_o <= reg_waddr_i;
            illegal_o   <= 1'b0;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand     <= mcand << 1;
          mplier    <= mplier >> 1;
          count     <= count + 1'b1;
          reg_we_o  <= 1'b0;
          illegal_o <= 1'b0;
          if (count == SW'(DATA_WIDTH-1)) state <= DONE;
        end
        DONE: begin
          reg_wdata_o <= acc;
          reg_we_o    <= mul_we && (mul_waddr != '0);
          reg_waddr_o <= mul_waddr;
          illegal_o   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for ex: expectations are queued when an instruction is issued and
// compared when the stage consumes it (a clock edge with stall_o low).
`timescale 1ns/1ps
module tb_ex;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] op1_i, op2_i, inst_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        illegal_o;
  logic        stall_o;

  always #5 clk_i = ~clk_i;

  ex #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op1_i(op1_i), .op2_i(op2_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .inst_i(inst_i),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .illegal_o(illegal_o), .stall_o(stall_o)
  );

  typedef struct {
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  waddr;
    logic        ill;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  valid    = 1'b0;
  logic  take_pending = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'b0, f3, 5'b0, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'b0, f3, 5'b0, 7'b0010011};
  endfunction

  // Monitor: compares on the negedge after a consuming edge, otherwise expects a bubble.
  always @(negedge clk_i) begin
    #2;
    if (take_pending) begin
      exp_t  e;
      string t;
      check_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        $display("txn %s: wdata=%h we=%b waddr=%0d illegal=%b", t, reg_wdata_o, reg_we_o,
                 reg_waddr_o, illegal_o);
        check_val({t, ".wdata"}, reg_wdata_o, e.wdata);
        check_val({t, ".we"}, 32'(reg_we_o), 32'(e.we));
        check_val({t, ".waddr"}, 32'(reg_waddr_o), 32'(e.waddr));
        check_val({t, ".illegal"}, 32'(illegal_o), 32'(e.ill));
      end
    end else begin
      check_val("bubble", {30'b0, reg_we_o, illegal_o}, 32'd0);
    end
    take_pending = valid && rst_i && !stall_o;
  end

  task automatic send(input string tag, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic we, input logic [4:0] wa,
                      input logic [31:0] ew, input logic ewe, input logic eill,
                      input int exp_stall);
    exp_t e;
    int   n;
    @(negedge clk_i);
    #1;
    inst_i = ins; op1_i = a; op2_i = b; reg_we_i = we; reg_waddr_i = wa; valid = 1'b1;
    e.wdata = ew; e.we = ewe; e.waddr = (eill || ewe || ew != 0 || wa != 0) ? wa : 5'd0;
    e.ill = eill;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    n = 0;
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk_i);
      #2;
    end
    check_val({tag, ".stall_cycles"}, 32'(n), 32'(exp_stall));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk_i);
      #1;
      valid = 1'b0; inst_i = NOP; reg_we_i = 1'b0; reg_waddr_i = 5'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    inst_i = r_op(7'b0000001, 3'b000);  // MUL held during reset: stall must stay low
    op1_i = 32'd3; op2_i = 32'd4; reg_we_i = 1'b1; reg_waddr_i = 5'd1;
    #12;
    check_val("reset.wdata", reg_wdata_o, 32'd0);
    check_val("reset.ctrl", {27'b0, reg_we_o, illegal_o, stall_o, 2'b0}, 32'd0);
    check_val("reset.waddr", 32'(reg_waddr_o), 32'd0);
    inst_i = NOP; reg_we_i = 1'b0; reg_waddr_i = 5'd0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;

    send("add_wrap", r_op(7'h00, 3'b000), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3, 32'h0, 1'b1, 1'b0, 0);
    send("sub",      r_op(7'h20, 3'b000), 32'd5, 32'd7, 1'b1, 5'd10, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
    send("sra",      r_op(7'h20, 3'b101), 32'h8000_0000, 32'd4, 1'b1, 5'd4, 32'hF800_0000, 1'b1, 1'b0, 0);
    send("srl",      r_op(7'h00, 3'b101), 32'h8000_0000, 32'd4, 1'b1, 5'd4, 32'h0800_0000, 1'b1, 1'b0, 0);
    send("sltu",     r_op(7'h00, 3'b011), 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd11, 32'd1, 1'b1, 1'b0, 0);
    send("slt",      r_op(7'h00, 3'b010), 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd12, 32'd0, 1'b1, 1'b0, 0);
    send("slti",     i_op(7'h00, 3'b010), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd13, 32'd1, 1'b1, 1'b0, 0);
    send("xori",     i_op(7'h00, 3'b100), 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b1, 5'd14, 32'h0F0F_0F0F, 1'b1, 1'b0, 0);
    send("slli",     i_op(7'h00, 3'b001), 32'd1, 32'd31, 1'b1, 5'd15, 32'h8000_0000, 1'b1, 1'b0, 0);
    send("and",      r_op(7'h00, 3'b111), 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd16, 32'h0F00_0F00, 1'b1, 1'b0, 0);
    send("srai",     i_op(7'h20, 3'b101), 32'hF000_0000, 32'd8, 1'b1, 5'd17, 32'hFFF0_0000, 1'b1, 1'b0, 0);

    send("mul_a",    r_op(7'h01, 3'b000), 32'h0001_2345, 32'h0000_0100, 1'b1, 5'd5, 32'h0123_4500, 1'b1, 1'b0, 33);
    // Back-to-back: MUL, MUL, then an ADD held behind the stall.
    send("mul_ones", r_op(7'h01, 3'b000), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd6, 32'h0000_0001, 1'b1, 1'b0, 33);
    send("mul_b2b",  r_op(7'h01, 3'b000), 32'd7, 32'd6, 1'b1, 5'd8, 32'd42, 1'b1, 1'b0, 33);
    send("add_after_mul", r_op(7'h00, 3'b000), 32'd100, 32'd23, 1'b1, 5'd9, 32'd123, 1'b1, 1'b0, 0);

    send("illegal",  32'hFFFF_FFFF, 32'd1, 32'd2, 1'b1, 5'd9, 32'd0, 1'b0, 1'b1, 0);
    send("mulh_ill", r_op(7'h01, 3'b001), 32'd1, 32'd2, 1'b1, 5'd18, 32'd0, 1'b0, 1'b1, 0);
    send("nop",      NOP, 32'd0, 32'd0, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 0);
    send("addi_x0",  i_op(7'h00, 3'b000), 32'd5, 32'd7, 1'b1, 5'd0, 32'd12, 1'b0, 1'b0, 0);
    send("mul_x0",   r_op(7'h01, 3'b000), 32'd3, 32'd3, 1'b1, 5'd0, 32'd9, 1'b0, 1'b0, 33);
    idle(2);

    // Reset in the middle of a multiply: cycle 11 after issue is BUSY with counter 10.
    @(negedge clk_i);
    #1;
    inst_i = r_op(7'h01, 3'b000); op1_i = 32'd3; op2_i = 32'd4; reg_we_i = 1'b1;
    reg_waddr_i = 5'd20; valid = 1'b1;
    repeat (11) @(negedge clk_i);
    #3;
    valid = 1'b0;
    rst_i = 1'b0;
    #1;
    check_val("rst_mid.wdata", reg_wdata_o, 32'd0);
    check_val("rst_mid.waddr", 32'(reg_waddr_o), 32'd0);
    check_val("rst_mid.ctrl", {29'b0, reg_we_o, illegal_o, stall_o}, 32'd0);
    inst_i = NOP; reg_we_i = 1'b0; reg_waddr_i = 5'd0;
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b1;
    send("add_post_rst", r_op(7'h00, 3'b000), 32'd2, 32'd3, 1'b1, 5'd7, 32'd5, 1'b1, 1'b0, 0);
    idle(40);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex.md
Name: ex

Overview:
- Execute stage, directly downstream of the ID/EXE pipeline register. Consumes op1/op2, instruction and write-back control.
- Computes the RV32I ALU result plus a 32-cycle iterative MUL (M-extension, low word).
- Registers result and write-back control toward the EXE/MEM side.
- Asserts stall_o while a multiply is in progress so upstream holds its outputs.

Parameters:
- DATA_WIDTH, 32, instruction and operand width.
- RADDR_WIDTH, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- op1_i  in  DATA_WIDTH  operand 1.
- op2_i  in  DATA_WIDTH  operand 2 (register or sign-extended immediate).
- reg_we_i  in  1  write enable from ID/EXE.
- reg_waddr_i  in  RADDR_WIDTH  destination register.
- inst_i  in  DATA_WIDTH  instruction word.
- reg_wdata_o  out  DATA_WIDTH  registered result.
- reg_we_o  out  1  registered write enable.
- reg_waddr_o  out  RADDR_WIDTH  registered destination register.
- illegal_o  out  1  registered one-cycle flag for an unsupported instruction.
- stall_o  out  1  combinational; 1 = upstream must hold its registers.

Behaviour:
- Reset (rst_i=0, asynchronous): reg_wdata_o=0, reg_we_o=0, reg_waddr_o=0, illegal_o=0, state=IDLE, counter=0. stall_o=0 while in reset.
- Decode from opcode inst_i[6:0], funct3 inst_i[14:12], funct7 inst_i[31:25]:
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (SRAI when inst_i[30]=1).
  - OP 0110011 with funct7 0000000/0100000: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - OP with funct7 0000001 and funct3 000: MUL.
  - All other encodings are illegal. The NOP encoding (ADDI x0,x0,0) is legal.
- Arithmetic rules:
  - Shift amount = op2_i[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 0 or 1.
  - ADD/SUB/MUL wrap modulo 2^32. MUL returns the low 32 bits.
- FSM states IDLE, BUSY, DONE:
  - IDLE, non-MUL instruction: stall_o=0. Next edge: reg_wdata_o=ALU result, reg_we_o=reg_we_i AND (reg_waddr_i!=0), reg_waddr_o=reg_waddr_i, illegal_o=0. Latency 1 cycle.
  - IDLE, illegal instruction: next edge reg_we_o=0, reg_wdata_o=0, reg_waddr_o=reg_waddr_i, illegal_o=1 for exactly one cycle.
  - IDLE, MUL: stall_o=1 combinationally in the same cycle. Next edge latches multiplicand=op1_i, multiplier=op2_i, product accumulator=0, counter=0, reg_we and waddr copies; state→BUSY. Outputs that edge: reg_we_o=0 (bubble).
  - BUSY: stall_o=1; one shift-add step per cycle (if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1); counter+1; reg_we_o=0, illegal_o=0. After the step with counter=31 (32 steps), state→DONE.
  - DONE: stall_o=0. Upstream still presents the same MUL; inst_i is ignored this cycle. Next edge: reg_wdata_o=acc, reg_we_o=latched we AND (latched waddr!=0), reg_waddr_o=latched waddr; state→IDLE.
- MUL timing: presented at cycle 0, stall_o high cycles 0..32, result visible after edge 34.
- Back-to-back MULs: the second MUL is evaluated in IDLE and restarts the sequence; no stall gap is required between them.
- Reset asserted mid-MUL: immediate return to IDLE; partial product discarded; no write emitted.
- A write to x0 never produces reg_we_o=1.

Test Plan:
- Reset: rst_i=0 mid-run → all outputs 0 and stall_o=0 immediately, without waiting for a clock edge.
- ALU: ADD op1=0xFFFFFFFF, op2=1, waddr=3, we=1 → next cycle reg_wdata_o=0, reg_we_o=1, reg_waddr_o=3. SRA op1=0x80000000, op2=4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1. SLT 1 vs 0xFFFFFFFF → 0.
- MUL: op1=0x00012345, op2=0x00000100, waddr=5 → stall_o high exactly 33 cycles, then reg_wdata_o=0x01234500, reg_we_o=1 for one cycle. MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Illegal: inst_i=0xFFFFFFFF → next cycle illegal_o=1 for one cycle, reg_we_o=0. x0 destination: ADDI x0 with we=1 → reg_we_o=0.
- Reset mid-MUL: assert rst_i=0 at BUSY counter=10, release, then present ADD 2+3 waddr=7 → reg_wdata_o=5 one cycle later; no MUL write ever appears.
- Back-to-back: MUL then ADD held behind stall → ADD result appears exactly one cycle after the MUL result, with no lost or duplicated write.
